// File: rtl/g2x_pkt_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : g2x_pkt_rd_ctrl
// Brief    : Packet read controller. Pops one byte count per packet from the
//            byte-count FIFO, reads ceil(bcnt/BPW) words from the data FIFO,
//            forwards them to the XGMII side with idle fill in between,
//            enforces a minimum inter-packet gap and drops zero-length or
//            oversize packets. Keeps packet/drop counters and a sticky
//            underrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module g2x_pkt_rd_ctrl #(
    parameter int DW    = 64,
    parameter int BCW   = 16,
    parameter int IPG_W = 4,
    parameter int CW    = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              en,
    input  logic [IPG_W-1:0]  ipg_cfg,
    input  logic [BCW-1:0]    max_words,
    input  logic              bcnt_empty,
    input  logic [BCW-1:0]    bcnt_in,
    input  logic              data_empty,
    input  logic [DW-1:0]     data_in,
    input  logic [DW/8-1:0]   ctrl_in,
    output logic              bcnt_re,
    output logic              data_re,
    output logic [DW-1:0]     data_out,
    output logic [DW/8-1:0]   ctrl_out,
    output logic [CW-1:0]     pkt_cnt,
    output logic [CW-1:0]     drop_cnt,
    output logic              underrun
);

    localparam int c_BPW = DW / 8;
    localparam int c_SH  = $clog2(c_BPW);

    localparam logic [DW-1:0]    c_IDLE_DATA = {c_BPW{8'h07}};
    localparam logic [c_BPW-1:0] c_IDLE_CTRL = {c_BPW{1'b1}};

    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        RD_BCNT  = 6'b000010,
        BCNT_BUF = 6'b000100,
        RD_DATA  = 6'b001000,
        DROP     = 6'b010000,
        GAP      = 6'b100000
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BCW:0]        w_wcnt_new;
    logic [BCW:0]        r_wcnt;
    logic [IPG_W-1:0]    r_gap;
    logic [IPG_W-1:0]    w_gap_load;
    logic                w_bad_len;
    logic                r_bcnt_re;
    logic                r_data_re;
    logic                r_fwd_d1;
    logic [DW-1:0]       r_data_out;
    logic [c_BPW-1:0]    r_ctrl_out;
    logic [CW-1:0]       r_pkt_cnt;
    logic [CW-1:0]       r_drop_cnt;
    logic                r_underrun;

    // Word count: whole words plus one for any partial trailing word.
    // Computed one bit wider than the byte count so it never overflows.
    generate
        if (c_SH > 0) begin : g_round
            assign w_wcnt_new = {1'b0, {c_SH{1'b0}}, bcnt_in[BCW-1:c_SH]}
                              + {{BCW{1'b0}}, |bcnt_in[c_SH-1:0]};
        end else begin : g_noround
            assign w_wcnt_new = {1'b0, bcnt_in};
        end
    endgenerate

    // A configured gap of zero still inserts one idle word.
    assign w_gap_load = (ipg_cfg == '0) ? IPG_W'(1) : ipg_cfg;
    assign w_bad_len  = (w_wcnt_new == '0) || (w_wcnt_new > {1'b0, max_words});

    // State register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en && !bcnt_empty) begin
                    w_state_nxt = RD_BCNT;
                end
            end
            RD_BCNT: begin
                w_state_nxt = BCNT_BUF;
            end
            BCNT_BUF: begin
                if (w_wcnt_new == '0) begin
                    w_state_nxt = GAP;
                end else if (w_wcnt_new > {1'b0, max_words}) begin
                    w_state_nxt = DROP;
                end else begin
                    w_state_nxt = RD_DATA;
                end
            end
            RD_DATA, DROP: begin
                if (r_wcnt == (BCW+1)'(1)) begin
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (r_gap <= IPG_W'(1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Word and gap counters.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wcnt <= '0;
            r_gap  <= '0;
        end else begin
            case (r_state)
                BCNT_BUF: begin
                    r_wcnt <= w_wcnt_new;
                    if (w_wcnt_new == '0) begin
                        r_gap <= w_gap_load;
                    end
                end
                RD_DATA, DROP: begin
                    r_wcnt <= r_wcnt - (BCW+1)'(1);
                    if (r_wcnt == (BCW+1)'(1)) begin
                        r_gap <= w_gap_load;
                    end
                end
                GAP: begin
                    r_gap <= r_gap - IPG_W'(1);
                end
                default: begin
                    r_gap <= r_gap;
                end
            endcase
        end
    end

    // FIFO pops registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_bcnt_re <= 1'b0;
            r_data_re <= 1'b0;
        end else begin
            r_bcnt_re <= (w_state_nxt == RD_BCNT);
            r_data_re <= (w_state_nxt == RD_DATA) || (w_state_nxt == DROP);
        end
    end

    // Output stage: forward a word the cycle after its read, idle otherwise.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_fwd_d1   <= 1'b0;
            r_data_out <= c_IDLE_DATA;
            r_ctrl_out <= c_IDLE_CTRL;
        end else begin
            r_fwd_d1 <= r_data_re && (r_state == RD_DATA);
            if (r_fwd_d1) begin
                r_data_out <= data_in;
                r_ctrl_out <= ctrl_in;
            end else begin
                r_data_out <= c_IDLE_DATA;
                r_ctrl_out <= c_IDLE_CTRL;
            end
        end
    end

    // Statistics and sticky underrun; the read is never stalled on underrun.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
            r_underrun <= 1'b0;
        end else begin
            if ((r_state == RD_DATA) && (r_wcnt == (BCW+1)'(1))) begin
                r_pkt_cnt <= r_pkt_cnt + CW'(1);
            end
            if ((r_state == BCNT_BUF) && w_bad_len) begin
                r_drop_cnt <= r_drop_cnt + CW'(1);
            end
            if (r_data_re && data_empty) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign bcnt_re  = r_bcnt_re;
    assign data_re  = r_data_re;
    assign data_out = r_data_out;
    assign ctrl_out = r_ctrl_out;
    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_g2x_pkt_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_g2x_pkt_rd_ctrl
// Brief    : Self-checking bench for g2x_pkt_rd_ctrl with behavioural FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_g2x_pkt_rd_ctrl;

    localparam int DW    = 64;
    localparam int BCW   = 16;
    localparam int IPG_W = 4;
    localparam int CW    = 32;
    localparam logic [DW-1:0] IDLE_D = {8{8'h07}};

    logic              clk = 1'b0;
    logic              reset_ = 1'b0;
    logic              en = 1'b0;
    logic [IPG_W-1:0]  ipg_cfg = 4'd3;
    logic [BCW-1:0]    max_words = 16'd16;
    logic              bcnt_empty = 1'b1;
    logic [BCW-1:0]    bcnt_in = '0;
    logic              data_empty = 1'b1;
    logic [DW-1:0]     data_in = '0;
    logic [7:0]        ctrl_in = '0;
    logic              bcnt_re, data_re, underrun;
    logic [DW-1:0]     data_out;
    logic [7:0]        ctrl_out;
    logic [CW-1:0]     pkt_cnt, drop_cnt;

    g2x_pkt_rd_ctrl #(.DW(DW), .BCW(BCW), .IPG_W(IPG_W), .CW(CW)) dut (
        .clk(clk), .reset_(reset_), .en(en), .ipg_cfg(ipg_cfg),
        .max_words(max_words), .bcnt_empty(bcnt_empty), .bcnt_in(bcnt_in),
        .data_empty(data_empty), .data_in(data_in), .ctrl_in(ctrl_in),
        .bcnt_re(bcnt_re), .data_re(data_re), .data_out(data_out),
        .ctrl_out(ctrl_out), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    // FIFO models and monitor state
    logic [BCW-1:0]  bq[$];
    logic [DW+7:0]   dq[$];
    logic [DW+7:0]   exp_q[$];
    logic [DW+7:0]   out_q[$];
    int              out_cyc[$];
    int              bre_cyc[$];
    int              dre_cyc[$];
    int              cyc = 0;
    logic            force_empty = 1'b0;
    int              n_chk = 0;
    int              n_pass = 0;
    int              seed = 1;
    int              exp_pkt = 0;
    int              exp_drop = 0;

    // FIFO read side: data valid the cycle after the pop
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bcnt_re && bq.size() > 0) bcnt_in <= bq.pop_front();
        if (data_re) begin
            if (dq.size() > 0) {ctrl_in, data_in} <= dq.pop_front();
            else {ctrl_in, data_in} <= '0;
        end
    end

    // Monitor and empty-flag update, away from the active edge
    always @(negedge clk) begin
        if (bcnt_re) bre_cyc.push_back(cyc);
        if (data_re) dre_cyc.push_back(cyc);
        if (data_out != IDLE_D || ctrl_out != 8'hFF) begin
            out_q.push_back({ctrl_out, data_out});
            out_cyc.push_back(cyc);
        end
        bcnt_empty = (bq.size() == 0);
        data_empty = (dq.size() == 0) || force_empty;
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clr_mon();
        @(posedge clk);
        out_q.delete(); out_cyc.delete(); bre_cyc.delete(); dre_cyc.delete();
    endtask

    task automatic push_pkt(input logic [BCW-1:0] b, input int nw, input bit fwd);
        logic [DW+7:0] w;
        bq.push_back(b);
        for (int i = 0; i < nw; i++) begin
            w = {(i == nw-1) ? 8'hF0 : 8'h00, 16'hC0DE, 16'(seed), 32'(i)};
            dq.push_back(w);
            if (fwd) exp_q.push_back(w);
        end
        seed++;
    endtask

    task automatic wait_done();
        int quiet = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (bq.size() == 0 && !bcnt_re && !data_re) quiet++;
            else quiet = 0;
            if (quiet >= 24) return;
        end
        n_chk++;
        $display("FAIL wait_done: timed out, bq=%0d dq=%0d", bq.size(), dq.size());
    endtask

    task automatic chk_words(input string name);
        chk({name, "_nwords"}, 72'(out_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            chk({name, "_word"}, out_q[i], exp_q[i]);
        exp_q.delete();
    endtask

    typedef struct {
        logic [BCW-1:0]   bcnt;
        logic [BCW-1:0]   maxw;
        logic [IPG_W-1:0] ipg;
        int               reads;
        bit               fwd;
        int               pkt_inc;
        int               drop_inc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'd64,  16'd16, 4'd3, 8,  1'b1, 1, 0};
        vecs[1] = '{16'd65,  16'd16, 4'd3, 9,  1'b1, 1, 0};
        vecs[2] = '{16'd1,   16'd16, 4'd3, 1,  1'b1, 1, 0};
        vecs[3] = '{16'd0,   16'd16, 4'd3, 0,  1'b0, 0, 1};
        vecs[4] = '{16'd200, 16'd16, 4'd3, 25, 1'b0, 0, 1};
        vecs[5] = '{16'd128, 16'd16, 4'd0, 16, 1'b1, 1, 0};
        vecs[6] = '{16'd129, 16'd16, 4'd1, 17, 1'b0, 0, 1};
        vecs[7] = '{16'd7,   16'd16, 4'd2, 1,  1'b1, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bcnt_re", 72'(bcnt_re), 72'(0));
        chk("rst_data_re", 72'(data_re), 72'(0));
        chk("rst_data_out", 72'(data_out), 72'(IDLE_D));
        chk("rst_ctrl_out", 72'(ctrl_out), 72'(8'hFF));
        chk("rst_pkt_cnt", 72'(pkt_cnt), 72'(0));
        chk("rst_drop_cnt", 72'(drop_cnt), 72'(0));
        chk("rst_underrun", 72'(underrun), 72'(0));
        reset_ = 1'b1;
        @(negedge clk);

        // Table-driven single packets
        en = 1'b1;
        for (int v = 0; v < 8; v++) begin
            clr_mon();
            @(negedge clk);
            ipg_cfg = vecs[v].ipg;
            max_words = vecs[v].maxw;
            push_pkt(vecs[v].bcnt, vecs[v].reads, vecs[v].fwd);
            wait_done();
            exp_pkt += vecs[v].pkt_inc;
            exp_drop += vecs[v].drop_inc;
            chk($sformatf("v%0d_reads", v), 72'(dre_cyc.size()), 72'(vecs[v].reads));
            chk_words($sformatf("v%0d", v));
            chk($sformatf("v%0d_pkt_cnt", v), 72'(pkt_cnt), 72'(exp_pkt));
            chk($sformatf("v%0d_drop_cnt", v), 72'(drop_cnt), 72'(exp_drop));
        end

        // Latency and inter-packet gap with ipg=3, two queued packets
        begin
            int c0;
            en = 1'b0; ipg_cfg = 4'd3; max_words = 16'd16;
            clr_mon();
            @(negedge clk);
            push_pkt(16'd64, 8, 1'b1);
            push_pkt(16'd64, 8, 1'b1);
            repeat (2) @(negedge clk);
            c0 = cyc;
            en = 1'b1;
            wait_done();
            exp_pkt += 2;
            if (bre_cyc.size() == 2 && dre_cyc.size() == 16 && out_cyc.size() == 16) begin
                chk("lat_bcnt_re", 72'(bre_cyc[0]), 72'(c0 + 1));
                chk("lat_first_re", 72'(dre_cyc[0]), 72'(c0 + 3));
                chk("lat_contig_re", 72'(dre_cyc[7] - dre_cyc[0]), 72'(7));
                chk("lat_first_out", 72'(out_cyc[0]), 72'(c0 + 5));
                chk("lat_contig_out", 72'(out_cyc[7] - out_cyc[0]), 72'(7));
                chk("lat_last_out", 72'(out_cyc[7]), 72'(dre_cyc[7] + 2));
                chk("gap3_interval", 72'(bre_cyc[1] - dre_cyc[7]), 72'(5));
            end else begin
                chk("lat_counts", 72'({bre_cyc.size(), dre_cyc.size(), out_cyc.size()}),
                    72'({32'd2, 32'd16, 32'd16}));
            end
            chk_words("lat");
            chk("lat_pkt_cnt", 72'(pkt_cnt), 72'(exp_pkt));
        end

        // ipg_cfg=0 behaves as a gap of one
        clr_mon();
        @(negedge clk);
        ipg_cfg = 4'd0;
        push_pkt(16'd16, 2, 1'b1);
        push_pkt(16'd16, 2, 1'b1);
        wait_done();
        exp_pkt += 2;
        if (bre_cyc.size() == 2 && dre_cyc.size() == 4)
            chk("gap0_interval", 72'(bre_cyc[1] - dre_cyc[1]), 72'(3));
        else
            chk("gap0_counts", 72'({bre_cyc.size(), dre_cyc.size()}), 72'({32'd2, 32'd4}));
        chk_words("gap0");

        // en low with a non-empty FIFO: no pop until en rises
        en = 1'b0;
        clr_mon();
        @(negedge clk);
        ipg_cfg = 4'd2;
        push_pkt(16'd24, 3, 1'b1);
        repeat (12) @(negedge clk);
        chk("en_low_no_pop", 72'(bre_cyc.size()), 72'(0));
        en = 1'b1;
        wait_done();
        exp_pkt += 1;
        chk("en_high_pop", 72'(bre_cyc.size()), 72'(1));
        chk_words("en");
        chk("en_pkt_cnt", 72'(pkt_cnt), 72'(exp_pkt));

        // Underrun: sticky until reset, reads continue
        chk("pre_underrun", 72'(underrun), 72'(0));
        clr_mon();
        @(negedge clk);
        force_empty = 1'b1;
        push_pkt(16'd64, 8, 1'b0);
        wait_done();
        force_empty = 1'b0;
        chk("underrun_set", 72'(underrun), 72'(1));
        chk("underrun_reads", 72'(dre_cyc.size()), 72'(8));
        clr_mon();
        @(negedge clk);
        push_pkt(16'd8, 1, 1'b1);
        wait_done();
        chk("underrun_sticky", 72'(underrun), 72'(1));
        chk_words("post_underrun");

        // Reset in the middle of RD_DATA
        clr_mon();
        @(negedge clk);
        push_pkt(16'd64, 8, 1'b0);
        begin
            int k;
            for (k = 0; k < 50 && !data_re; k++) @(negedge clk);
            chk("mid_reached_rd", 72'(data_re), 72'(1));
        end
        repeat (3) @(negedge clk);
        #1 reset_ = 1'b0;
        #1;
        chk("mid_rst_data_out", 72'(data_out), 72'(IDLE_D));
        chk("mid_rst_ctrl_out", 72'(ctrl_out), 72'(8'hFF));
        chk("mid_rst_data_re", 72'(data_re), 72'(0));
        chk("mid_rst_pkt_cnt", 72'(pkt_cnt), 72'(0));
        chk("mid_rst_drop_cnt", 72'(drop_cnt), 72'(0));
        chk("mid_rst_underrun", 72'(underrun), 72'(0));
        bq.delete(); dq.delete(); exp_q.delete();
        @(negedge clk);
        reset_ = 1'b1;
        clr_mon();
        @(negedge clk);
        push_pkt(16'd20, 3, 1'b1);
        wait_done();
        chk("post_rst_reads", 72'(dre_cyc.size()), 72'(3));
        chk_words("post_rst");
        chk("post_rst_pkt_cnt", 72'(pkt_cnt), 72'(1));
        chk("post_rst_drop_cnt", 72'(drop_cnt), 72'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
